// File: rtl/hs_fifo_pkg.sv
// Shared constants for the hs_fifo handshake buffer: handshake rates and counter width.
package hs_fifo_pkg;

    localparam int COUNT_WIDTH = 32;

    // A responder that only acks on req & ~ack produces at most one ack every two cycles.
    localparam int PROD_ACK_PERIOD = 2;

    typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/hs_fifo_mem.sv
// depth x data_width register array: synchronous write, combinational read.
module hs_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_fifo.sv
// Req/ack buffer between a dataflow output port and a consumer; one word per two cycles
// downstream, 2-edge empty latency; up_req is withheld so a compliant producer never overflows.
module hs_fifo
    import hs_fifo_pkg::*;
#(
    parameter  int data_width = 32,
    parameter  int depth      = 4,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   up_req,
    input  logic                   up_ack,
    input  logic [data_width-1:0]  up_din,
    input  logic                   dn_req,
    output logic                   dn_ack,
    output logic [data_width-1:0]  dn_dout,
    output logic [addr_width:0]    level,
    output logic [COUNT_WIDTH-1:0] count_in,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   ovf
);

    localparam logic [addr_width:0] LVL_FULL  = (addr_width+1)'(depth);
    // Leave room for the one ack that may still arrive after req is dropped.
    localparam logic [addr_width:0] REQ_LIMIT = (addr_width+1)'(depth - PROD_ACK_PERIOD);

    logic [addr_width-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [addr_width:0]   level_q, level_d, level_pushed;
    logic                  up_req_q, up_req_d;
    logic                  dn_ack_q, dn_ack_d;
    logic                  ovf_q, ovf_d;
    logic [data_width-1:0] dout_q, dout_d, rdata;
    count_t                cin_q, cin_d, cout_q, cout_d;
    logic                  full, push, pop;

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (up_din),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        full         = (level_q == LVL_FULL);
        push         = up_ack && !full;
        // Pop uses the pre-push level, so a word is never read in the edge it is written.
        pop          = dn_req && !dn_ack_q && (level_q != '0);
        level_pushed = level_q + (addr_width+1)'(push);
        level_d      = level_pushed - (addr_width+1)'(pop);
        wptr_d       = push ? wptr_q + addr_width'(1) : wptr_q;
        rptr_d       = pop  ? rptr_q + addr_width'(1) : rptr_q;
        cin_d        = cin_q + count_t'(push);
        cout_d       = cout_q + count_t'(pop);
        ovf_d        = ovf_q || (up_ack && full);
        dn_ack_d     = pop;
        dout_d       = pop ? rdata : dout_q;

        if (up_ack) begin
            up_req_d = (level_pushed <= REQ_LIMIT);
        end else if (!up_req_q) begin
            up_req_d = (level_d < LVL_FULL);
        end else begin
            up_req_d = up_req_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            up_req_q <= 1'b0;
            dn_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            cin_q    <= '0;
            cout_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            up_req_q <= up_req_d;
            dn_ack_q <= dn_ack_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            cin_q    <= cin_d;
            cout_q   <= cout_d;
        end
    end

    assign up_req    = up_req_q;
    assign dn_ack    = dn_ack_q;
    assign dn_dout   = dout_q;
    assign level     = level_q;
    assign count_in  = cin_q;
    assign count_out = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hs_fifo.sv
// Directed and random-stall bench for hs_fifo with a scoreboard queue.
module tb_hs_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          up_req, up_ack, dn_req, dn_ack, ovf;
    logic [DW-1:0] up_din, dn_dout;
    logic [AW:0]   level;
    logic [31:0]   count_in, count_out;

    hs_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_ack    (up_ack),
        .up_din    (up_din),
        .dn_req    (dn_req),
        .dn_ack    (dn_ack),
        .dn_dout   (dn_dout),
        .level     (level),
        .count_in  (count_in),
        .count_out (count_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [DW-1:0] sb[$];
    int            exp_level;
    logic [31:0]   n_in, n_out;
    bit            prev_pop, ovf_m, seen3;
    bit            prod_en, cons_en, rand_data;
    int            prod_left, prod_fail, cons_fail;
    logic [DW-1:0] seq_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_level = 0;
        sb.delete();
        n_in     = '0;
        n_out    = '0;
        prev_pop = 1'b0;
        ovf_m    = 1'b0;
    endtask

    // One clock edge: predict push/pop from the inputs, then compare after the edge.
    task automatic step();
        bit            push_m, pop_m;
        logic [DW-1:0] d, e;
        push_m = up_ack && (exp_level < DEPTH);
        pop_m  = dn_req && !prev_pop && (exp_level > 0);
        d      = up_din;
        if (up_ack && !push_m) ovf_m = 1'b1;
        @(posedge clk);
        #1;
        check("dn_ack", dn_ack, pop_m);
        if (pop_m) begin
            e = sb.pop_front();
            check("dn_dout", dn_dout, e);
            n_out++;
            exp_level--;
        end
        if (push_m) begin
            sb.push_back(d);
            n_in++;
            exp_level++;
        end
        check("level", level, exp_level);
        check("ovf", ovf, ovf_m);
        check("count_in", count_in, n_in);
        check("count_out", count_out, n_out);
        prev_pop = pop_m;
    endtask

    // Producer acks only on req & ~ack; consumer requests with a random stall rate.
    task automatic auto_drive();
        bit nack;
        nack = prod_en && (prod_left > 0) && up_req && !up_ack &&
               ($urandom_range(99) >= prod_fail);
        if (nack) begin
            up_din = rand_data ? $urandom() : seq_val;
            seq_val++;
            prod_left--;
        end
        up_ack = nack;
        dn_req = cons_en && ($urandom_range(99) >= cons_fail);
    endtask

    task automatic do_reset();
        up_ack = 1'b0;
        dn_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst_up_req", up_req, 0);
        check("rst_dn_ack", dn_ack, 0);
        check("rst_dn_dout", dn_dout, 0);
        check("rst_level", level, 0);
        check("rst_count_in", count_in, 0);
        check("rst_count_out", count_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        step();
        check("rst_release_up_req", up_req, 1);
    endtask

    initial begin
        rst = 1'b0; up_ack = 1'b0; dn_req = 1'b0; up_din = '0;
        prod_en = 1'b0; cons_en = 1'b0; rand_data = 1'b0; seen3 = 1'b0;
        prod_left = 0; prod_fail = 0; cons_fail = 0; seq_val = '0;
        reset_model();
        do_reset();

        // Pass-through of 0..9 with an always-requesting consumer.
        prod_en = 1'b1; cons_en = 1'b1; prod_left = 10;
        for (int i = 0; i < 300 && n_out < 10; i++) begin auto_drive(); step(); end
        check("pt_words", n_out, 10);
        check("pt_count_in", count_in, 10);
        check("pt_count_out", count_out, 10);
        check("pt_level", level, 0);
        check("pt_ovf", ovf, 0);

        // Fill with consumer idle.
        cons_en = 1'b0; prod_left = 1000;
        for (int i = 0; i < 60 && exp_level < 4; i++) begin auto_drive(); step(); end
        check("fill_level", level, 4);
        check("fill_up_req", up_req, 0);
        repeat (10) begin auto_drive(); step(); end
        check("fill_hold_level", level, 4);
        check("fill_hold_up_req", up_req, 0);
        check("fill_count_in", count_in, 14);
        check("fill_ovf", ovf, 0);

        // Drain from full; up_req returns once level leaves full.
        prod_en = 1'b0; cons_en = 1'b1;
        for (int i = 0; i < 40 && exp_level > 0; i++) begin
            auto_drive(); step();
            if (exp_level == 3 && !seen3) begin
                seen3 = 1'b1;
                check("drain_up_req", up_req, 1);
            end
        end
        check("drain_level", level, 0);
        check("drain_count_out", count_out, 14);

        // Simultaneous push and pop at level 2.
        cons_en = 1'b0; prod_en = 1'b1; prod_left = 2;
        for (int i = 0; i < 30 && exp_level < 2; i++) begin auto_drive(); step(); end
        repeat (3) begin auto_drive(); step(); end
        check("sim_pre_up_req", up_req, 1);
        up_ack = 1'b1; up_din = 32'hA5A5_0001; dn_req = 1'b1;
        step();
        check("sim_level", level, 2);
        check("sim_dn_ack", dn_ack, 1);
        check("sim_count_in", count_in, 17);
        check("sim_count_out", count_out, 15);
        up_ack = 1'b0; dn_req = 1'b0; prod_en = 1'b0; cons_en = 1'b1;
        for (int i = 0; i < 30 && exp_level > 0; i++) begin auto_drive(); step(); end
        check("sim_drain_level", level, 0);

        // Asynchronous reset mid-cycle with level 3.
        cons_en = 1'b0; prod_en = 1'b1; prod_left = 3;
        for (int i = 0; i < 40 && exp_level < 3; i++) begin auto_drive(); step(); end
        repeat (3) begin auto_drive(); step(); end
        check("rst_pre_level", level, 3);
        do_reset();

        // Ack forced while full: word dropped, ovf sticky.
        cons_en = 1'b0; prod_en = 1'b1; prod_left = 1000;
        for (int i = 0; i < 60 && exp_level < 4; i++) begin auto_drive(); step(); end
        prod_en = 1'b0;
        repeat (3) begin auto_drive(); step(); end
        up_ack = 1'b1; up_din = 32'h0000_DEAD;
        step();
        up_ack = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_level", level, 4);
        check("ovf_count_in", count_in, 4);
        repeat (3) begin auto_drive(); step(); end
        check("ovf_sticky", ovf, 1);
        cons_en = 1'b1;
        for (int i = 0; i < 40 && exp_level > 0; i++) begin auto_drive(); step(); end
        check("ovf_after_drain", ovf, 1);
        check("ovf_count_out", count_out, 4);
        do_reset();

        // Random stalls on both sides, 5000 words.
        prod_en = 1'b1; cons_en = 1'b1; prod_fail = 30; cons_fail = 30;
        rand_data = 1'b1; prod_left = 5000;
        for (int i = 0; i < 40000 && n_out < 5000; i++) begin auto_drive(); step(); end
        check("rnd_words", n_out, 5000);
        check("rnd_count_in", count_in, 5000);
        check("rnd_count_out", count_out, 5000);
        check("rnd_level", level, 0);
        check("rnd_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
